// File: rtl/soc_dmem.sv
// soc_dmem: data-memory slave for the SOC DMEM window.
// Single-port, byte-writable RAM behind a small IDLE/RWAIT/ACK FSM. Every
// accepted transaction ends with a registered one-cycle rdy pulse. Reads can
// be stretched by RD_WAIT wait states to exercise the master's ack path.
//
// Optional feature: define SOC_DMEM_RANGE_CHK_EN to add the err output and
// reject accesses whose address bits above the RAM index are non-zero.
// Without it, those upper bits are ignored and the RAM aliases across the window.
//
// Ports:
//   clk   - bus clock
//   rst   - synchronous active-high reset
//   vld   - request, held by the master until it sees rdy
//   addr  - word address (byte address [31:2])
//   we    - byte write enables; 4'h0 means read
//   wdat  - write data
//   rdy   - one-cycle completion pulse (registered)
//   rdat  - read data, valid with rdy and held afterwards
//   err   - (SOC_DMEM_RANGE_CHK_EN only) out-of-range flag, pulses with rdy
module soc_dmem #(
  parameter int unsigned NUM_WORDS = 8192,
  parameter int unsigned RD_WAIT   = 0,
  parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [29:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdat,
  output logic        rdy,
  output logic [31:0] rdat
`ifdef SOC_DMEM_RANGE_CHK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW        = $clog2(NUM_WORDS);
  localparam logic [3:0]  RdWaitCnt = 4'(RD_WAIT);

  typedef enum logic [1:0] {StIdle, StRwait, StAck} state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    cnt_q;
  logic [31:0]   mem [NUM_WORDS];

  logic [AW-1:0] idx;
  logic          wr_req;
  logic [31:0]   rd_now;   // data for a zero-wait read, indexed by the live address
  logic [31:0]   rd_late;  // data for a waited read, indexed by the latched address

  assign idx    = addr[AW-1:0];
  assign wr_req = (state_q == StIdle) && vld && (|we);

`ifdef SOC_DMEM_RANGE_CHK_EN
  logic oor;
  logic oor_q;
  assign oor     = (addr >> AW) != 30'd0;
  assign rd_now  = oor   ? 32'hDEAD_BEEF : mem[idx];
  assign rd_late = oor_q ? 32'hDEAD_BEEF : mem[idx_q];
`else
  logic unused_addr;
  assign unused_addr = ^(addr >> AW);
  assign rd_now      = mem[idx];
  assign rd_late     = mem[idx_q];
`endif

  // RAM array: never reset. A write commits on its acceptance edge.
  always_ff @(posedge clk) begin
`ifdef SOC_DMEM_RANGE_CHK_EN
    if (!rst && wr_req && !oor) begin
`else
    if (!rst && wr_req) begin
`endif
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  // Control FSM with registered rdy/rdat/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rdy     <= 1'b0;
      rdat    <= INIT_VAL;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
`ifdef SOC_DMEM_RANGE_CHK_EN
      err     <= 1'b0;
      oor_q   <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
`ifdef SOC_DMEM_RANGE_CHK_EN
      err <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (vld) begin
            idx_q <= idx;
`ifdef SOC_DMEM_RANGE_CHK_EN
            oor_q <= oor;
`endif
            if ((|we) || (RD_WAIT == 0)) begin
              // Writes and zero-wait reads complete in the next cycle.
              if (~|we) rdat <= rd_now;
              state_q <= StAck;
              rdy     <= 1'b1;
`ifdef SOC_DMEM_RANGE_CHK_EN
              err     <= oor;
`endif
            end else begin
              cnt_q   <= RdWaitCnt;
              state_q <= StRwait;
            end
          end
        end
        StRwait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            rdat    <= rd_late;
            state_q <= StAck;
            rdy     <= 1'b1;
`ifdef SOC_DMEM_RANGE_CHK_EN
            err     <= oor_q;
`endif
          end
        end
        // vld is still high here from the finishing transaction; ignore it.
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_dmem.sv
// Testbench for soc_dmem. Three instances with different depth/wait/reset
// values share one clock; a scoreboard queue holds the expected completion of
// each transaction and a small byte-lane memory model supplies read data.
module tb_soc_dmem;

  logic        clk;
  logic        rst_s  [3];
  logic        vld_s  [3];
  logic [29:0] addr_s [3];
  logic [3:0]  we_s   [3];
  logic [31:0] wdat_s [3];
  logic        rdy_s  [3];
  logic [31:0] rdat_s [3];
`ifdef SOC_DMEM_RANGE_CHK_EN
  logic        err_s  [3];
`endif

  int          words  [3] = '{8192, 16, 64};
  int          rdw    [3] = '{0, 3, 5};
  logic [31:0] init_v [3] = '{32'h0000_0000, 32'h1111_2222, 32'h5A5A_A5A5};

  typedef struct {
    int          lat;
    bit          rd;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd [3];
  int          rdy_cnt [3];
  int          exp_rdy [3];
  int          n_checks;
  int          n_errors;

  soc_dmem #(.NUM_WORDS(8192), .RD_WAIT(0), .INIT_VAL(32'h0000_0000)) u_dmem_a (
    .clk(clk), .rst(rst_s[0]), .vld(vld_s[0]), .addr(addr_s[0]), .we(we_s[0]),
    .wdat(wdat_s[0]), .rdy(rdy_s[0]), .rdat(rdat_s[0])
`ifdef SOC_DMEM_RANGE_CHK_EN
    , .err(err_s[0])
`endif
  );

  soc_dmem #(.NUM_WORDS(16), .RD_WAIT(3), .INIT_VAL(32'h1111_2222)) u_dmem_b (
    .clk(clk), .rst(rst_s[1]), .vld(vld_s[1]), .addr(addr_s[1]), .we(we_s[1]),
    .wdat(wdat_s[1]), .rdy(rdy_s[1]), .rdat(rdat_s[1])
`ifdef SOC_DMEM_RANGE_CHK_EN
    , .err(err_s[1])
`endif
  );

  soc_dmem #(.NUM_WORDS(64), .RD_WAIT(5), .INIT_VAL(32'h5A5A_A5A5)) u_dmem_c (
    .clk(clk), .rst(rst_s[2]), .vld(vld_s[2]), .addr(addr_s[2]), .we(we_s[2]),
    .wdat(wdat_s[2]), .rdy(rdy_s[2]), .rdat(rdat_s[2])
`ifdef SOC_DMEM_RANGE_CHK_EN
    , .err(err_s[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every cycle rdy is high; a stretched or repeated pulse shows up here.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy_s[d]) rdy_cnt[d] <= rdy_cnt[d] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance d. Caller is #1 after a clock edge. from_ack
  // means the previous transaction left the DUT in ACK with vld still high.
  task automatic xact(input int d, input logic [29:0] a, input logic [3:0] w,
                      input logic [31:0] wd, input bit from_ack, input bit keep,
                      output logic [31:0] obs);
    exp_t        e;
    int          n;
    bit          got;
    int          key;
    bit          oor;
    logic [31:0] cur;
    oor = 1'b0;
`ifdef SOC_DMEM_RANGE_CHK_EN
    oor = int'(a) >= words[d];
`endif
    key   = d * 16384 + (int'(a) % words[d]);
    e.rd  = (w == 4'h0);
    e.lat = (e.rd ? rdw[d] + 1 : 1) + (from_ack ? 1 : 0);
    e.err = oor;
    if (e.rd) begin
      e.dat = oor ? 32'hDEAD_BEEF : mdl[key];
    end else begin
      e.dat = last_rd[d];
      if (!oor) begin
        cur = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (w[i]) cur[8*i +: 8] = wd[8*i +: 8];
        end
        mdl[key] = cur;
      end
    end
    sb.push_back(e);

    vld_s[d]  = 1'b1;
    addr_s[d] = a;
    we_s[d]   = w;
    wdat_s[d] = wd;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy_s[d]) got = 1'b1;
    end

    e = sb.pop_front();
    check("done", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(e.lat));
    check(e.rd ? "rdat" : "rdat_after_write", rdat_s[d], e.dat);
`ifdef SOC_DMEM_RANGE_CHK_EN
    check("err", 32'(err_s[d]), 32'(e.err));
`endif
    if (got) exp_rdy[d]++;
    if (e.rd) last_rd[d] = e.dat;
    obs = rdat_s[d];

    if (!keep) begin
      vld_s[d] = 1'b0;
      we_s[d]  = 4'h0;
      @(posedge clk);
      #1;
      check("rdy_one_cycle", 32'(rdy_s[d]), 32'd0);
      check("rdat_stable", rdat_s[d], last_rd[d]);
    end
  endtask

  initial begin
    logic [31:0] r;
    bit          saw;
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < 3; d++) begin
      rst_s[d]   = 1'b1;
      vld_s[d]   = 1'b0;
      addr_s[d]  = '0;
      we_s[d]    = '0;
      wdat_s[d]  = '0;
      rdy_cnt[d] = 0;
      exp_rdy[d] = 0;
      last_rd[d] = init_v[d];
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("reset_rdy", 32'(rdy_s[d]), 32'd0);
      check("reset_rdat", rdat_s[d], init_v[d]);
    end

    // Byte-lane writes then read (instance A, no wait states).
    xact(0, 30'h0100_0001, 4'hF, 32'h1234_5678, 1'b0, 1'b0, r);
    xact(0, 30'h0100_0001, 4'b0010, 32'hFFFF_AAFF, 1'b0, 1'b0, r);
    xact(0, 30'h0100_0001, 4'h0, 32'h0, 1'b0, 1'b0, r);
`ifndef SOC_DMEM_RANGE_CHK_EN
    check("byte_merge", r, 32'h1234_AA78);
`endif

    // Back-to-back with vld held through ACK.
    xact(0, 30'h55, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b1, r);
    xact(0, 30'h55, 4'h0, 32'h0, 1'b1, 1'b0, r);
    check("b2b_read_new", r, 32'h0BAD_F00D);
    xact(0, 30'h60, 4'hF, 32'hA0A0_0060, 1'b0, 1'b1, r);
    xact(0, 30'h61, 4'hC, 32'hB1B1_0000, 1'b1, 1'b1, r);
    xact(0, 30'h60, 4'h0, 32'h0, 1'b1, 1'b0, r);

    // Instance B: 16 words, RD_WAIT=3, aliasing / range check.
    xact(1, 30'h01, 4'hF, 32'h0000_0B0B, 1'b0, 1'b0, r);
    xact(1, 30'h11, 4'hF, 32'hCAFE_0001, 1'b0, 1'b0, r);
    xact(1, 30'h01, 4'h0, 32'h0, 1'b0, 1'b0, r);
`ifdef SOC_DMEM_RANGE_CHK_EN
    check("oor_write_untouched", r, 32'h0000_0B0B);
`else
    check("alias_read", r, 32'hCAFE_0001);
`endif
    xact(1, 30'h11, 4'h0, 32'h0, 1'b0, 1'b0, r);
`ifdef SOC_DMEM_RANGE_CHK_EN
    check("oor_read", r, 32'hDEAD_BEEF);
`endif
    xact(1, 30'h01, 4'h0, 32'h0, 1'b0, 1'b1, r);
    xact(1, 30'h01, 4'h0, 32'h0, 1'b1, 1'b0, r);

    // Instance C: RD_WAIT=5, reset in the middle of a read.
    xact(2, 30'h03, 4'hF, 32'h7777_8888, 1'b0, 1'b0, r);
    xact(2, 30'h03, 4'h0, 32'h0, 1'b0, 1'b0, r);
    vld_s[2]  = 1'b1;
    addr_s[2] = 30'h03;
    we_s[2]   = 4'h0;
    saw = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    if (rdy_s[2]) saw = 1'b1;
    rst_s[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[2] = 1'b0;
    vld_s[2] = 1'b0;
    check("rst_mid_read_rdat", rdat_s[2], init_v[2]);
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rdy_s[2]) saw = 1'b1;
    end
    check("rst_mid_read_no_rdy", 32'(saw), 32'd0);
    last_rd[2] = init_v[2];
    xact(2, 30'h03, 4'h0, 32'h0, 1'b0, 1'b0, r);
    check("read_after_reset", r, 32'h7777_8888);

    for (int d = 0; d < 3; d++) check("rdy_pulse_count", 32'(rdy_cnt[d]), 32'(exp_rdy[d]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
